row_cmd_sequencer: RTL and testbench

//  Front end to the open-row policy block. Accepts one memory request at a time and looks it up in the

---
 rtl/row_cmd_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_row_cmd_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_cmd_sequencer.sv
// Request front end for the open-row policy block: policy lookup, PRE/ACT/RD/WR issue with
// tRP/tRCD spacing, and the PREA -> REF refresh sequence that clears the policy table.
module row_cmd_sequencer #(
    parameter int unsigned T_RCD = 16,
    parameter int unsigned T_RP  = 16,
    parameter int unsigned T_RFC = 280,
    parameter int unsigned COL_W = 10
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_bank_group,
    input  logic [1:0]       req_bank,
    input  logic [15:0]      req_row,
    input  logic [COL_W-1:0] req_col,
    output logic             req_done,
    input  logic             ref_req,
    output logic             ref_ack,
    output logic             pol_req_en,
    output logic [1:0]       pol_bank_group,
    output logic [1:0]       pol_bank,
    output logic [15:0]      pol_row,
    output logic             pol_row_resolve,
    output logic             pol_refresh,
    input  logic [1:0]       pol_row_stat,
    output logic             cmd_valid,
    output logic [2:0]       cmd,
    output logic [1:0]       cmd_bank_group,
    output logic [1:0]       cmd_bank,
    output logic [15:0]      cmd_row,
    output logic [COL_W-1:0] cmd_col
);

    localparam int unsigned CNT_W = $clog2(T_RFC) + 1;

    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 2);

    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_ACT  = 3'b001;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_PREA = 3'b011;
    localparam logic [2:0] CMD_RD   = 3'b100;
    localparam logic [2:0] CMD_WR   = 3'b101;
    localparam logic [2:0] CMD_REF  = 3'b110;

    typedef enum logic [3:0] {
        StIdle,
        StLookup,
        StStat,
        StAct,
        StWaitRcd,
        StPre,
        StWaitRp,
        StResolve,
        StRdwr,
        StRefPrea,
        StRefWaitRp,
        StRef,
        StRefWaitRfc
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [1:0]         bg_q, bg_d;
    logic [1:0]         bank_q, bank_d;
    logic [15:0]        row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            bg_q    <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            bg_q    <= bg_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign req_ready = (state_q == StIdle) && !ref_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        bg_d    = bg_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            StIdle: begin
                if (ref_req) begin
                    state_d = StRefPrea;
                end else if (req_valid) begin
                    write_d = req_write;
                    bg_d    = req_bank_group;
                    bank_d  = req_bank;
                    row_d   = req_row;
                    col_d   = req_col;
                    state_d = StLookup;
                end
            end
            StLookup: state_d = StStat;
            StStat: begin
                unique case (pol_row_stat)
                    2'b01:   state_d = StRdwr;
                    2'b10:   state_d = StAct;
                    2'b11:   state_d = StPre;
                    default: state_d = StLookup;
                endcase
            end
            StAct: begin
                cnt_d   = RCD_LOAD;
                state_d = StWaitRcd;
            end
            StWaitRcd: begin
                if (cnt_q == '0) state_d = StRdwr;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            StPre: begin
                cnt_d   = RP_LOAD;
                state_d = StWaitRp;
            end
            StWaitRp: begin
                if (cnt_q == '0) state_d = StResolve;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            StResolve: state_d = StLookup;
            StRdwr:    state_d = StIdle;
            StRefPrea: begin
                cnt_d   = RP_LOAD;
                state_d = StRefWaitRp;
            end
            StRefWaitRp: begin
                if (cnt_q == '0) state_d = StRef;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            StRef: begin
                cnt_d   = RFC_LOAD;
                state_d = StRefWaitRfc;
            end
            StRefWaitRfc: begin
                if (cnt_q == '0) state_d = StIdle;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    // Command fields carry the latched request only for per-bank commands; NOP/PREA/REF drive 0.
    always_comb begin
        cmd             = CMD_NOP;
        req_done        = 1'b0;
        ref_ack         = 1'b0;
        pol_req_en      = 1'b0;
        pol_row_resolve = 1'b0;
        pol_refresh     = 1'b0;
        unique case (state_q)
            StLookup:  pol_req_en = 1'b1;
            StAct:     cmd = CMD_ACT;
            StPre:     cmd = CMD_PRE;
            StResolve: begin
                pol_req_en      = 1'b1;
                pol_row_resolve = 1'b1;
            end
            StRdwr: begin
                cmd      = write_q ? CMD_WR : CMD_RD;
                req_done = 1'b1;
            end
            StRefPrea: cmd = CMD_PREA;
            StRef: begin
                cmd         = CMD_REF;
                pol_refresh = 1'b1;
            end
            StRefWaitRfc: ref_ack = (cnt_q == '0);
            default: ;
        endcase
    end

    assign cmd_valid      = (cmd != CMD_NOP);
    assign pol_bank_group = bg_q;
    assign pol_bank       = bank_q;
    assign pol_row        = row_q;

    logic bank_cmd;
    assign bank_cmd       = (cmd == CMD_ACT) || (cmd == CMD_PRE) || (cmd == CMD_RD) ||
                            (cmd == CMD_WR);
    assign cmd_bank_group = bank_cmd ? bg_q : 2'b00;
    assign cmd_bank       = bank_cmd ? bank_q : 2'b00;
    assign cmd_row        = bank_cmd ? row_q : 16'h0000;
    assign cmd_col        = bank_cmd ? col_q : '0;

endmodule

// File: tb/tb_row_cmd_sequencer.sv
// Bench for row_cmd_sequencer: behavioural open-row policy, per-transaction schedule model,
// directed scenarios followed by randomized requests and refreshes.
module tb_row_cmd_sequencer;

    localparam int T_RCD = 4;
    localparam int T_RP  = 3;
    localparam int T_RFC = 8;
    localparam int COL_W = 10;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_ACT  = 3'd1;
    localparam logic [2:0] C_PRE  = 3'd2;
    localparam logic [2:0] C_PREA = 3'd3;
    localparam logic [2:0] C_RD   = 3'd4;
    localparam logic [2:0] C_WR   = 3'd5;
    localparam logic [2:0] C_REF  = 3'd6;

    logic             CLK, nRST;
    logic             req_valid, req_ready, req_write;
    logic [1:0]       req_bank_group, req_bank;
    logic [15:0]      req_row;
    logic [COL_W-1:0] req_col;
    logic             req_done, ref_req, ref_ack;
    logic             pol_req_en, pol_row_resolve, pol_refresh;
    logic [1:0]       pol_bank_group, pol_bank, pol_row_stat;
    logic [15:0]      pol_row;
    logic             cmd_valid;
    logic [2:0]       cmd;
    logic [1:0]       cmd_bank_group, cmd_bank;
    logic [15:0]      cmd_row;
    logic [COL_W-1:0] cmd_col;

    row_cmd_sequencer #(
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .COL_W(COL_W)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bank_group(req_bank_group), .req_bank(req_bank), .req_row(req_row),
        .req_col(req_col), .req_done(req_done), .ref_req(ref_req), .ref_ack(ref_ack),
        .pol_req_en(pol_req_en), .pol_bank_group(pol_bank_group), .pol_bank(pol_bank),
        .pol_row(pol_row), .pol_row_resolve(pol_row_resolve), .pol_refresh(pol_refresh),
        .pol_row_stat(pol_row_stat), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_bank_group(cmd_bank_group), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
        .cmd_col(cmd_col)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Policy block: miss opens the row, resolve invalidates, refresh clears everything.
    logic        pv [16];
    logic [15:0] pr [16];
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pol_row_stat <= 2'b00;
            for (int i = 0; i < 16; i++) pv[i] <= 1'b0;
        end else begin
            pol_row_stat <= 2'b00;
            if (pol_refresh) begin
                for (int i = 0; i < 16; i++) pv[i] <= 1'b0;
            end else if (pol_req_en) begin
                if (pol_row_resolve) begin
                    pv[{pol_bank_group, pol_bank}] <= 1'b0;
                end else if (!pv[{pol_bank_group, pol_bank}]) begin
                    pv[{pol_bank_group, pol_bank}] <= 1'b1;
                    pr[{pol_bank_group, pol_bank}] <= pol_row;
                    pol_row_stat <= 2'b10;
                end else begin
                    pol_row_stat <= (pr[{pol_bank_group, pol_bank}] == pol_row) ? 2'b01 : 2'b11;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          last_cyc, last_gap;
    logic        have_last = 1'b0;
    logic        exp_v [16];
    logic [15:0] exp_r [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int gap_of(input logic [2:0] c);
        case (c)
            C_ACT:         return T_RCD;
            C_PRE, C_PREA: return T_RP;
            C_REF:         return T_RFC;
            default:       return 1;
        endcase
    endfunction

    function automatic logic [63:0] outs_vec();
        return 64'({req_done, ref_ack, pol_req_en, pol_bank_group, pol_bank, pol_row,
                    pol_row_resolve, pol_refresh, cmd_valid, cmd, cmd_bank_group, cmd_bank,
                    cmd_row, cmd_col});
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) exp_v[i] = 1'b0;
    endtask

    // Advance to the next falling edge and audit cmd_valid and command spacing.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (nRST === 1'b1) begin
            chk("audit_cmd_valid", 64'(cmd_valid), 64'(cmd != C_NOP));
            if (cmd_valid === 1'b1) begin
                if (have_last) chk("audit_spacing", 64'(cyc - last_cyc), 64'((cyc - last_cyc) >= last_gap ? cyc - last_cyc : last_gap));
                have_last = 1'b1;
                last_cyc  = cyc;
                last_gap  = gap_of(cmd);
            end
        end else begin
            have_last = 1'b0;
        end
    endtask

    task automatic run_req(input logic w, input logic [1:0] bg, input logic [1:0] bk,
                           input logic [15:0] row, input logic [COL_W-1:0] col,
                           input int abort_at, output int rdwr_cyc);
        int key, kind, fin, n;
        logic [2:0] ecmd, rw;
        logic en, res;
        key = int'({bg, bk});
        if (!exp_v[key]) kind = 1;
        else if (exp_r[key] == row) kind = 0;
        else kind = 2;
        rw  = w ? C_WR : C_RD;
        fin = (kind == 0) ? 3 : (kind == 1) ? 3 + T_RCD : 6 + T_RP + T_RCD;
        req_write = w; req_bank_group = bg; req_bank = bk; req_row = row; req_col = col;
        req_valid = 1'b1;
        #1;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) begin
            chk("accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            rdwr_cyc  = 0;
            return;
        end
        rdwr_cyc = cyc + fin;
        tick();
        req_valid = 1'b0;
        for (int off = 1; off <= fin; off++) begin
            ecmd = C_NOP;
            if (off == fin) ecmd = rw;
            else if (off == 3) ecmd = (kind == 1) ? C_ACT : C_PRE;
            else if (kind == 2 && off == 6 + T_RP) ecmd = C_ACT;
            en  = (off == 1) || (kind == 2 && (off == 3 + T_RP || off == 4 + T_RP));
            res = (kind == 2) && (off == 3 + T_RP);
            chk("seq", 64'({cmd, req_done, pol_req_en, pol_row_resolve, req_ready}),
                64'({ecmd, (off == fin), en, res, 1'b0}));
            if (off == 1)
                chk("pol_fields", 64'({pol_bank_group, pol_bank, pol_row}), 64'({bg, bk, row}));
            if (ecmd != C_NOP)
                chk("cmd_fields", 64'({cmd_bank_group, cmd_bank, cmd_row, cmd_col}),
                    64'({bg, bk, row, col}));
            if (off == abort_at) begin
                nRST = 1'b0;
                #1;
                chk("reset_outputs", outs_vec(), 64'd0);
                chk("reset_ready", 64'(req_ready), 64'd1);
                clear_model();
                return;
            end
            tick();
        end
        chk("idle_after", 64'({cmd_valid, req_ready}), 64'(2'b01));
        exp_v[key] = 1'b1;
        exp_r[key] = row;
    endtask

    task automatic run_ref();
        int fin;
        logic [2:0] ecmd;
        fin = T_RP + T_RFC;
        ref_req = 1'b1;
        #1;
        chk("ready_gated", 64'(req_ready), 64'd0);
        tick();
        for (int off = 1; off <= fin; off++) begin
            ecmd = C_NOP;
            if (off == 1) ecmd = C_PREA;
            else if (off == 1 + T_RP) ecmd = C_REF;
            chk("ref_seq", 64'({cmd, ref_ack, pol_refresh, req_ready}),
                64'({ecmd, (off == fin), (off == 1 + T_RP), 1'b0}));
            if (ecmd != C_NOP)
                chk("ref_fields", 64'({cmd_bank_group, cmd_bank, cmd_row, cmd_col}), 64'd0);
            if (off == fin) ref_req = 1'b0;
            tick();
        end
        chk("ready_after_ref", 64'({cmd_valid, ref_ack, req_ready}), 64'(3'b001));
        clear_model();
    endtask

    initial begin
        int r, prev;
        logic [1:0] rbg, rbk;
        logic [15:0] rrow;
        nRST = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_bank_group = '0; req_bank = '0;
        req_row = '0; req_col = '0; ref_req = 1'b0;
        clear_model();
        tick();
        tick();
        chk("reset_outputs", outs_vec(), 64'd0);
        nRST = 1'b1;
        tick();
        chk("post_reset_outputs", outs_vec(), 64'd0);
        chk("post_reset_ready", 64'(req_ready), 64'd1);

        // Cold read (MISS), same-row read (HIT), different-row write (CONFLICT).
        run_req(1'b0, 2'd1, 2'd2, 16'h00A5, 10'd7, 0, r);
        run_req(1'b0, 2'd1, 2'd2, 16'h00A5, 10'd7, 0, r);
        run_req(1'b1, 2'd1, 2'd2, 16'h0100, 10'd9, 0, r);

        // Refresh wins over a simultaneous request; the old row then misses.
        req_write = 1'b0; req_bank_group = 2'd1; req_bank = 2'd2; req_row = 16'h0100;
        req_col = 10'd3; req_valid = 1'b1;
        run_ref();
        run_req(1'b0, 2'd1, 2'd2, 16'h0100, 10'd3, 0, r);

        // Reset in the middle of the tRCD wait, then a fresh request.
        run_req(1'b0, 2'd2, 2'd0, 16'h0055, 10'd1, 5, r);
        tick();
        chk("reset_hold_outputs", outs_vec(), 64'd0);
        nRST = 1'b1;
        tick();
        run_req(1'b1, 2'd2, 2'd0, 16'h0055, 10'd2, 0, r);

        // Open four banks, then four back-to-back hits.
        run_req(1'b0, 2'd0, 2'd0, 16'h0011, 10'd0, 0, r);
        run_req(1'b0, 2'd0, 2'd1, 16'h0022, 10'd0, 0, r);
        run_req(1'b0, 2'd3, 2'd2, 16'h0033, 10'd0, 0, r);
        run_req(1'b0, 2'd3, 2'd3, 16'h0044, 10'd0, 0, r);
        run_req(1'b0, 2'd0, 2'd0, 16'h0011, 10'd5, 0, prev);
        run_req(1'b1, 2'd0, 2'd1, 16'h0022, 10'd6, 0, r);
        chk("b2b_spacing", 64'(r - prev), 64'd4);
        prev = r;
        run_req(1'b0, 2'd3, 2'd2, 16'h0033, 10'd7, 0, r);
        chk("b2b_spacing", 64'(r - prev), 64'd4);
        prev = r;
        run_req(1'b1, 2'd3, 2'd3, 16'h0044, 10'd8, 0, r);
        chk("b2b_spacing", 64'(r - prev), 64'd4);

        // Randomized mix over a small row set so hits, misses and conflicts all occur.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                run_ref();
            end else begin
                rbg  = 2'($urandom_range(0, 3));
                rbk  = 2'($urandom_range(0, 1));
                rrow = 16'(16 * $urandom_range(1, 3));
                run_req(1'($urandom_range(0, 1)), rbg, rbk, rrow, COL_W'($urandom), 0, r);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
